lane_traffic_counter: RTL and testbench
=======================================

// Module: lane_traffic_counter
// PURPOSE
//  Upstream feeder of the Breadboard intersection controller. Turns per-lane loop-detector
//  levels into the packed 8x8-bit lane car-count bus, and optionally the emgSignal/emgLane pair.
//  Counts go up on arrivals, go down on departures, saturate at the top and floor at zero.
//  Outputs connect directly to the Breadboard lanes, emgSignal and emgLane inputs.
// PARAMETERS
//  NUM_LANES  8   lanes; bit/slot i: 7=W1 6=W2 5=S1 4=S2 3=E1 2=E2 1=N1 0=N2
//  CNT_W      8   width of each lane count
//  EMG_HOLD   4   consecutive beacon-high cycles needed to qualify an emergency (>=1)
// PORTS
//  clk        in   1                single clock, rising edge
//  rst        in   1                synchronous, active-low reset
//  arriveDet  in   NUM_LANES        arrival loop-detector levels, one per lane
//  departDet  in   NUM_LANES        departure (stop-line exit) detector levels
//  emgBeacon  in   NUM_LANES        emergency-vehicle beacon levels
//  lanesOut   out  NUM_LANES*CNT_W  counts; slot i = bits [i*CNT_W +: CNT_W] ({w1,w2,s1,s2,e1,e2,n1,n2})
//  underflow  out  NUM_LANES        sticky: departure seen while lane count was 0
//  emgSignal  out  1                emergency active
//  emgLane    out  NUM_LANES        one-hot lane granted emergency; 0 when inactive
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): all counts 0, underflow 0, detector history 0, emg FSM IDLE,
//   emgSignal 0, emgLane 0, hold counters 0. Reset mid-operation discards everything in flight.
//  Events: arrival(i)=arriveDet[i]&~prevA[i]; departure(i)=departDet[i]&~prevD[i]; prev* regs
//   sample the detector levels every cycle. A level held high is exactly one event.
//  Latency: a detector rising in cycle T changes lanesOut at the edge ending T (visible in T+1).
//  Count update per lane, evaluated each cycle:
//   arrive&depart     -> unchanged (even at 0 or MAX); no underflow
//   arrive only       -> +1; at MAX=2^CNT_W-1 holds MAX (saturate, no wrap)
//   depart only       -> -1; at 0 holds 0 and sets underflow[i]
//  underflow[i] clears only on reset. Lanes are fully independent of each other.
//  Emergency FSM (one instance; per-lane hold counters saturate at EMG_HOLD, reset when beacon low):
//   IDLE    -> QUALIFY when any beacon is high
//   QUALIFY -> ACTIVE when some lane's hold count reaches EMG_HOLD. Grant goes to the
//              highest-index qualifying lane (W1 has top priority). Latch the one-hot in emgLane
//              and set emgSignal in the same edge. -> IDLE if every beacon drops first.
//   ACTIVE  -> hold the grant while the granted lane's beacon stays high; other beacons are
//              ignored. When the granted beacon is low for 1 cycle: clear emgSignal/emgLane and go
//              to IDLE. Other lanes still high re-qualify from a fresh hold count.
//  emgLane is always one-hot or zero. It is nonzero exactly when emgSignal==1.
// CONFIGURATION
//  Macro LANE_EMG_DETECT_EN.
//   Defined: the emergency FSM and hold counters are as above.
//   Undefined: emgBeacon is ignored (port kept), emgSignal tied 0, emgLane tied 0, no FSM logic.
//   Counting and underflow are identical in both builds.
// STRUCTURE
//  traffic_pkg: lane index constants LANE_W1..LANE_N2, NUM_LANES default, emg state encodings
//   EMG_IDLE/EMG_QUALIFY/EMG_ACTIVE.
//  Sub-module lane_counter: one lane's edge detect, saturating up/down counter and sticky
//   underflow. Instantiated NUM_LANES times by generate. The top level holds the emergency FSM,
//   the hold counters and the priority grant.
// TESTING
//  1 Reset, then pulse arriveDet[7] high for 3 cycles, 3 times -> W1 slot==3; other slots 0;
//    underflow==0.
//  2 Lane 0 count 0, departDet[0] rises -> count stays 0, underflow[0]=1; it stays 1 until rst=0.
//  3 255 arrival edges on lane 4, then 1 more -> S2 slot==255 (no wrap). Then arrive+depart
//    rising in the same cycle -> stays 255.
//  4 (EN) emgBeacon[3] high 4 cycles -> on the 4th edge emgSignal=1, emgLane=8'b00001000.
//    Beacon high only 3 cycles -> emgSignal stays 0.
//  5 (EN) beacons 2 and 6 qualify in the same cycle -> emgLane=8'b01000000. Drop beacon 6
//    -> emgSignal=0 for one cycle, then lane 2 grants after EMG_HOLD more cycles.
//  6 Assert rst=0 mid-count with emgSignal=1 -> next cycle all slots 0, emgSignal=0, emgLane=0,
//    underflow=0.
//  Checks run in both macro builds; the undefined build asserts emgSignal==0 throughout.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lane numbering and emergency-FSM state encodings for the
// lane_traffic_counter slice.
package traffic_pkg;

  // Bit/slot index of each lane on the packed Breadboard lane bus.
  localparam int unsigned LANE_W1 = 7;
  localparam int unsigned LANE_W2 = 6;
  localparam int unsigned LANE_S1 = 5;
  localparam int unsigned LANE_S2 = 4;
  localparam int unsigned LANE_E1 = 3;
  localparam int unsigned LANE_E2 = 2;
  localparam int unsigned LANE_N1 = 1;
  localparam int unsigned LANE_N2 = 0;

  localparam int unsigned NUM_LANES_DEF = 8;

  typedef enum logic [1:0] {
    EMG_IDLE    = 2'd0,
    EMG_QUALIFY = 2'd1,
    EMG_ACTIVE  = 2'd2
  } emg_state_t;

endpackage : traffic_pkg

// File: rtl/lane_counter.sv
// One lane: rising-edge detect on the arrival and departure detectors,
// saturating up/down car count, and a sticky underflow flag.
module lane_counter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive_det,
  input  logic             depart_det,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic prev_a;
  logic prev_d;
  logic arrive;
  logic depart;

  // A detector level held high produces exactly one event on its rising edge.
  always_comb begin
    arrive = arrive_det & ~prev_a;
    depart = depart_det & ~prev_d;
  end

  // Detector history, saturating count and sticky underflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_a    <= 1'b0;
      prev_d    <= 1'b0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      prev_a <= arrive_det;
      prev_d <= depart_det;
      case ({arrive, depart})
        2'b10: begin
          if (count != '1) count <= count + 1'b1;
        end
        2'b01: begin
          if (count == '0) underflow <= 1'b1;
          else             count     <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : lane_counter

// File: rtl/lane_traffic_counter.sv
// Upstream feeder of the Breadboard intersection controller: per-lane car
// counts from loop detectors plus an optional emergency-vehicle grant.
// Optional feature macro: LANE_EMG_DETECT_EN (emergency FSM and hold counters).
module lane_traffic_counter
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned EMG_HOLD  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       arriveDet,
  input  logic [NUM_LANES-1:0]       departDet,
  input  logic [NUM_LANES-1:0]       emgBeacon,
  output logic [NUM_LANES*CNT_W-1:0] lanesOut,
  output logic [NUM_LANES-1:0]       underflow,
  output logic                       emgSignal,
  output logic [NUM_LANES-1:0]       emgLane
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_counter #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .arrive_det(arriveDet[i]),
      .depart_det(departDet[i]),
      .count     (lanesOut[i*CNT_W +: CNT_W]),
      .underflow (underflow[i])
    );
  end

`ifdef LANE_EMG_DETECT_EN

  localparam int unsigned HOLD_W = (EMG_HOLD < 2) ? 1 : $clog2(EMG_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(EMG_HOLD);

  emg_state_t           state_q;
  emg_state_t           state_d;
  logic [NUM_LANES-1:0] lane_q;
  logic [NUM_LANES-1:0] lane_d;
  logic [HOLD_W-1:0]    hold_q   [NUM_LANES];
  logic [HOLD_W-1:0]    hold_inc [NUM_LANES];
  logic [NUM_LANES-1:0] qualify;
  logic [NUM_LANES-1:0] grant_pick;

  // Next hold count per lane; a lane qualifies on the edge its count reaches EMG_HOLD.
  always_comb begin
    qualify = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      hold_inc[i] = '0;
      if (emgBeacon[i]) begin
        hold_inc[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
      end
      qualify[i] = (hold_inc[i] == HOLD_MAX);
    end
  end

  // Highest-index qualifying lane wins (W1 on top).
  always_comb begin
    grant_pick = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (qualify[i]) begin
        grant_pick    = '0;
        grant_pick[i] = 1'b1;
      end
    end
  end

  // Hold counters: held at zero while a grant is active, so any lane still
  // beaconing after the grant ends starts qualification afresh.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        hold_q[i] <= (state_q == EMG_ACTIVE) ? '0 : hold_inc[i];
      end
    end
  end

  // Emergency FSM state and latched one-hot grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMG_IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Emergency FSM next state; the grant is latched on the same edge as entry to ACTIVE.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      EMG_IDLE: begin
        if (|qualify) begin
          state_d = EMG_ACTIVE;
          lane_d  = grant_pick;
        end else if (|emgBeacon) begin
          state_d = EMG_QUALIFY;
        end
      end
      EMG_QUALIFY: begin
        if (|qualify) begin
          state_d = EMG_ACTIVE;
          lane_d  = grant_pick;
        end else if (~|emgBeacon) begin
          state_d = EMG_IDLE;
        end
      end
      EMG_ACTIVE: begin
        if (~|(emgBeacon & lane_q)) begin
          state_d = EMG_IDLE;
          lane_d  = '0;
        end
      end
      default: begin
        state_d = EMG_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // Emergency outputs follow the registered state and grant.
  always_comb begin
    emgSignal = (state_q == EMG_ACTIVE);
    emgLane   = lane_q;
  end

`else

  logic unused_emg_cfg;

  // Emergency detection not built: beacons are ignored and outputs are tied low.
  always_comb begin
    unused_emg_cfg = ^{emgBeacon, (EMG_HOLD > 0)};
    emgSignal      = 1'b0;
    emgLane        = '0;
  end

`endif

endmodule : lane_traffic_counter

// File: tb/tb_lane_traffic_counter.sv
// Directed self-checking bench for lane_traffic_counter; runs in both
// LANE_EMG_DETECT_EN builds, expecting emgSignal/emgLane low when undefined.
module tb_lane_traffic_counter;

`ifdef LANE_EMG_DETECT_EN
  localparam bit EMG_EN = 1'b1;
`else
  localparam bit EMG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  arriveDet;
  logic [7:0]  departDet;
  logic [7:0]  emgBeacon;
  logic [63:0] lanesOut;
  logic [7:0]  underflow;
  logic        emgSignal;
  logic [7:0]  emgLane;

  int n_cmp = 0;
  int n_err = 0;

  lane_traffic_counter #(
    .NUM_LANES(8),
    .CNT_W    (8),
    .EMG_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arriveDet(arriveDet),
    .departDet(departDet),
    .emgBeacon(emgBeacon),
    .lanesOut (lanesOut),
    .underflow(underflow),
    .emgSignal(emgSignal),
    .emgLane  (emgLane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    arriveDet = '0;
    departDet = '0;
    emgBeacon = '0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (lanesOut !== 64'h0) begin
      n_err++; $display("FAIL reset_counts: got %h want %h", lanesOut, 64'h0);
    end
    n_cmp++;
    if (underflow !== 8'h00) begin
      n_err++; $display("FAIL reset_underflow: got %h want 00", underflow);
    end
    n_cmp++;
    if (emgSignal !== 1'b0 || emgLane !== 8'h00) begin
      n_err++; $display("FAIL reset_emg: got sig=%b lane=%b want 0/00000000", emgSignal, emgLane);
    end
  endtask

  task automatic test_arrival();
    for (int p = 0; p < 3; p++) begin
      arriveDet[7] = 1'b1;
      tick(1);
      n_cmp++;
      if (lanesOut[63:56] !== 8'(p + 1)) begin
        n_err++; $display("FAIL arrival_latency: pulse %0d got %0d want %0d", p, lanesOut[63:56], p + 1);
      end
      tick(2);
      arriveDet[7] = 1'b0;
      tick(1);
    end
    n_cmp++;
    if (lanesOut !== 64'h0300_0000_0000_0000) begin
      n_err++; $display("FAIL arrival_w1: got %h want %h", lanesOut, 64'h0300_0000_0000_0000);
    end
    n_cmp++;
    if (underflow !== 8'h00) begin
      n_err++; $display("FAIL arrival_underflow: got %h want 00", underflow);
    end
  endtask

  task automatic test_underflow();
    departDet[0] = 1'b1;
    tick(1);
    n_cmp++;
    if (lanesOut[7:0] !== 8'd0 || underflow !== 8'h01) begin
      n_err++; $display("FAIL underflow_set: got cnt=%0d uf=%h want 0/01", lanesOut[7:0], underflow);
    end
    tick(2);
    departDet[0] = 1'b0;
    arriveDet[0] = 1'b1;
    tick(1);
    n_cmp++;
    if (lanesOut[7:0] !== 8'd1 || underflow !== 8'h01) begin
      n_err++; $display("FAIL underflow_sticky: got cnt=%0d uf=%h want 1/01", lanesOut[7:0], underflow);
    end
    arriveDet[0] = 1'b0;
    departDet[0] = 1'b1;
    tick(1);
    departDet[0] = 1'b0;
    tick(1);
    n_cmp++;
    if (lanesOut[7:0] !== 8'd0 || underflow !== 8'h01) begin
      n_err++; $display("FAIL underflow_dec: got cnt=%0d uf=%h want 0/01", lanesOut[7:0], underflow);
    end
    do_reset();
    n_cmp++;
    if (underflow !== 8'h00) begin
      n_err++; $display("FAIL underflow_clear: got %h want 00", underflow);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 255; k++) begin
      arriveDet[4] = 1'b1;
      tick(1);
      arriveDet[4] = 1'b0;
      tick(1);
    end
    n_cmp++;
    if (lanesOut[39:32] !== 8'd255) begin
      n_err++; $display("FAIL sat_reach: got %0d want 255", lanesOut[39:32]);
    end
    arriveDet[4] = 1'b1;
    tick(1);
    arriveDet[4] = 1'b0;
    tick(1);
    n_cmp++;
    if (lanesOut !== 64'h0000_00FF_0000_0000) begin
      n_err++; $display("FAIL sat_nowrap: got %h want %h", lanesOut, 64'h0000_00FF_0000_0000);
    end
    arriveDet[4] = 1'b1;
    departDet[4] = 1'b1;
    arriveDet[1] = 1'b1;
    departDet[1] = 1'b1;
    tick(1);
    n_cmp++;
    if (lanesOut !== 64'h0000_00FF_0000_0000 || underflow !== 8'h00) begin
      n_err++; $display("FAIL both_edges: got %h uf=%h want %h uf=00", lanesOut, underflow, 64'h0000_00FF_0000_0000);
    end
    arriveDet = '0;
    departDet = '0;
    tick(1);
    departDet[4] = 1'b1;
    tick(1);
    departDet[4] = 1'b0;
    n_cmp++;
    if (lanesOut[39:32] !== 8'd254) begin
      n_err++; $display("FAIL sat_dec: got %0d want 254", lanesOut[39:32]);
    end
  endtask

  task automatic test_emg_hold();
    do_reset();
    emgBeacon[3] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      n_cmp++;
      if (emgSignal !== (EMG_EN && c == 4) || emgLane !== ((EMG_EN && c == 4) ? 8'h08 : 8'h00)) begin
        n_err++; $display("FAIL emg_hold c%0d: got sig=%b lane=%b", c, emgSignal, emgLane);
      end
    end
    emgBeacon[3] = 1'b0;
    tick(1);
    n_cmp++;
    if (emgSignal !== 1'b0 || emgLane !== 8'h00) begin
      n_err++; $display("FAIL emg_release: got sig=%b lane=%b want 0/00000000", emgSignal, emgLane);
    end
    tick(1);
    emgBeacon[3] = 1'b1;
    tick(3);
    emgBeacon[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      n_cmp++;
      if (emgSignal !== 1'b0 || emgLane !== 8'h00) begin
        n_err++; $display("FAIL emg_short c%0d: got sig=%b lane=%b want 0/00000000", c, emgSignal, emgLane);
      end
    end
  endtask

  task automatic test_emg_priority();
    do_reset();
    emgBeacon[2] = 1'b1;
    emgBeacon[6] = 1'b1;
    tick(3);
    n_cmp++;
    if (emgSignal !== 1'b0) begin
      n_err++; $display("FAIL prio_early: got sig=%b want 0", emgSignal);
    end
    tick(1);
    n_cmp++;
    if (emgSignal !== EMG_EN || emgLane !== (EMG_EN ? 8'h40 : 8'h00)) begin
      n_err++; $display("FAIL prio_grant: got sig=%b lane=%b", emgSignal, emgLane);
    end
    emgBeacon[6] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      n_cmp++;
      if (emgSignal !== (EMG_EN && c == 5) || emgLane !== ((EMG_EN && c == 5) ? 8'h04 : 8'h00)) begin
        n_err++; $display("FAIL prio_regrant c%0d: got sig=%b lane=%b", c, emgSignal, emgLane);
      end
    end
    emgBeacon = '0;
    tick(1);
  endtask

  task automatic test_reset_midrun();
    do_reset();
    emgBeacon[5] = 1'b1;
    arriveDet[1] = 1'b1;
    arriveDet[5] = 1'b1;
    departDet[0] = 1'b1;
    tick(1);
    arriveDet = '0;
    departDet = '0;
    tick(1);
    arriveDet[5] = 1'b1;
    tick(2);
    n_cmp++;
    if (lanesOut !== 64'h0000_0200_0000_0100 || underflow !== 8'h01 || emgSignal !== EMG_EN) begin
      n_err++; $display("FAIL midrun_state: got %h uf=%h sig=%b", lanesOut, underflow, emgSignal);
    end
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if (lanesOut !== 64'h0 || underflow !== 8'h00 || emgSignal !== 1'b0 || emgLane !== 8'h00) begin
      n_err++; $display("FAIL midrun_reset: got %h uf=%h sig=%b lane=%b want all 0", lanesOut, underflow, emgSignal, emgLane);
    end
    rst = 1'b1;
    emgBeacon = '0;
    arriveDet = '0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_underflow();
    test_saturate();
    test_emg_hold();
    test_emg_priority();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_lane_traffic_counter
